regfile_mp: RTL

- Parametrised multi-port integer register file for the pipelined RISC-V core; successor to the single-write, two-read register file.
- Provides NRD combinational read ports, two posedge write ports with fixed priority, an optional hardwired-zero register, and a sequential soft-clear engine with a request/done handshake.
- Sits in ID: reads feed the ID/EX register; writes come from WB.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_clr_fsm.sv | 88 ++++++++
 rtl/regfile_mp.sv | 116 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults, soft-clear FSM state encoding and the
//                hardwired-zero register address for the multi-port
//                register file.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int DW_DEF    = 32;
    localparam int DEPTH_DEF = 32;
    localparam int NRD_DEF   = 2;

    // Register index that reads as zero and ignores writes when enabled
    localparam int ZERO_ADDR = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_clr_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_clr_fsm
//  Description : Soft-clear sequencer. Sweeps one register per cycle from
//                index 0 to DEPTH-1, then pulses clr_done for one cycle.
//  Ports       : clk, rst (async, active-low)
//                clr_req      - start request, sampled only in IDLE
//                clr_busy     - high while sweeping
//                clr_done     - one-cycle completion pulse
//                clr_en       - clear reg[clr_addr] at the next edge
//                clr_addr     - register being cleared this cycle
//                sweep_active - high in CLEAR and DONE (blocks writes/bypass)
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr,
    output logic          sweep_active
);

    clr_state_t    state;
    clr_state_t    state_nxt;
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        clr_busy     = 1'b0;
        clr_done     = 1'b0;
        clr_en       = 1'b0;
        sweep_active = 1'b1;
        case (state)
            IDLE: begin
                sweep_active = 1'b0;
                if (clr_req) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                clr_en   = 1'b1;
                // Last register is cleared on the same edge that leaves CLEAR,
                // so ptr never needs to wrap.
                if (ptr == AW'(DEPTH - 1)) begin
                    state_nxt = DONE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + AW'(1);
                end
            end
            DONE: begin
                clr_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                sweep_active = 1'b0;
                state_nxt    = IDLE;
                ptr_nxt      = '0;
            end
        endcase
    end

    assign clr_addr = ptr;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-port integer register file: NRD combinational read
//                ports, two posedge write ports (port 1 wins on address
//                collision), optional hardwired-zero register and a
//                sequential soft-clear engine.
//  Ports       : clk, rst (async, active-low)
//                ra/rd            - packed read address/data, port i at
//                                   [i*AW +: AW] / [i*DW +: DW]
//                we0/wa0/wd0      - write port 0
//                we1/wa1/wd1      - write port 1 (higher priority)
//                clr_req/clr_busy/clr_done - soft-clear handshake
//  Options     : define REGF_MP_BYPASS_EN for same-cycle write-to-read
//                forwarding; otherwise reads return the stored value.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AW       = $clog2(DEPTH),
    parameter int NRD      = NRD_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    logic [DW-1:0] mem [DEPTH];

    logic          clr_en;
    logic [AW-1:0] clr_addr;
    logic          sweep_active;
    logic          wr0_ok;
    logic          wr1_ok;

    regfile_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .clk          (clk),
        .rst          (rst),
        .clr_req      (clr_req),
        .clr_busy     (clr_busy),
        .clr_done     (clr_done),
        .clr_en       (clr_en),
        .clr_addr     (clr_addr),
        .sweep_active (sweep_active)
    );

    // Qualified write strobes: dropped while a sweep is in progress and,
    // with the zero register enabled, when targeting address 0.
    assign wr0_ok = we0 && !sweep_active &&
                    !((ZERO_REG != 0) && (wa0 == AW'(ZERO_ADDR)));
    assign wr1_ok = we1 && !sweep_active &&
                    !((ZERO_REG != 0) && (wa1 == AW'(ZERO_ADDR)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (clr_en) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr0_ok) begin
                mem[wa0] <= wd0;
            end
            // Issued after port 0 so it overrides on an address collision
            if (wr1_ok) begin
                mem[wa1] <= wd1;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] data;

        assign addr = ra[i*AW +: AW];

        always_comb begin
            data = mem[addr];
            if ((ZERO_REG != 0) && (addr == AW'(ZERO_ADDR))) begin
                data = '0;
            end
`ifdef REGF_MP_BYPASS_EN
            // wr*_ok already excludes sweeps and the zero register;
            // rst gating keeps reads at zero while reset is held.
            if (rst && wr0_ok && (wa0 == addr)) begin
                data = wd0;
            end
            if (rst && wr1_ok && (wa1 == addr)) begin
                data = wd1;
            end
`endif
        end

        assign rd[i*DW +: DW] = data;
    end

endmodule
`default_nettype wire
